// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_if
//  Description : Bundle between the ID stage and the hazard scoreboard.
//                The master side presents the decoded ID-stage instruction;
//                the slave side (the scoreboard) returns the pipeline
//                sequencing controls and status.
//  Ports       : id_*                     decoded instruction fields
//                pc_write, ifid_write     front-end write enables
//                ifid_flush, idex_bubble  NOP insertion controls
//                fp_busy, stall_cycles    status / performance counter
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             id_rs_fp;
    logic             id_rt_fp;
    logic [4:0]       id_dst;
    logic             id_dst_we;
    logic             id_dst_fp;
    logic             id_is_load;
    logic             id_is_fpop;
    logic             id_branch_taken;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             fp_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rs_fp,
               id_rt_fp, id_dst, id_dst_we, id_dst_fp, id_is_load,
               id_is_fpop, id_branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, fp_busy,
               stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rs_fp,
               id_rt_fp, id_dst, id_dst_we, id_dst_fp, id_is_load,
               id_is_fpop, id_branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_bubble, fp_busy,
               stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : ID-stage hazard controller for a 5-stage MIPS pipeline with
//                integer and FP register files. Keeps a per-register
//                countdown of cycles until a pending result is forwardable,
//                plus an occupancy countdown for the single non-pipelined
//                FP unit, and derives PC / IF/ID / ID/EX sequencing from it.
//  Ports       : clk    rising-edge clock
//                reset  asynchronous active-high, clears all state
//                bus    hazard_scoreboard_if.slave (instruction in, controls
//                       and status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int FP_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  bus
);

    if (FP_LAT < 2 || FP_LAT > 7) begin : g_bad_fp_lat
        $error("hazard_scoreboard: FP_LAT must be in 2..7");
    end

    localparam logic [2:0] c_fp_lat = 3'(FP_LAT);

    // Index 0..31 integer file, separate array for the FP file.
    logic [2:0]       r_gpr_cnt [32];
    logic [2:0]       r_fpr_cnt [32];
    logic [2:0]       r_fpu_cnt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic [2:0] w_rs_pend;
    logic [2:0] w_rt_pend;
    logic [2:0] w_dst_pend;
    logic       w_rs_haz;
    logic       w_rt_haz;
    logic       w_waw_haz;
    logic       w_struct_haz;
    logic       w_dst_is_r0;
    logic       w_stall;
    logic       w_issue;
    logic       w_wr_en;
    logic [2:0] w_load_val;

    assign w_rs_pend  = bus.id_rs_fp  ? r_fpr_cnt[bus.id_rs]  : r_gpr_cnt[bus.id_rs];
    assign w_rt_pend  = bus.id_rt_fp  ? r_fpr_cnt[bus.id_rt]  : r_gpr_cnt[bus.id_rt];
    assign w_dst_pend = bus.id_dst_fp ? r_fpr_cnt[bus.id_dst] : r_gpr_cnt[bus.id_dst];

    // Integer r0 is hardwired; it is never a real producer or consumer.
    assign w_dst_is_r0  = !bus.id_dst_fp && (bus.id_dst == 5'd0);
    assign w_rs_haz     = bus.id_rs_used && !(!bus.id_rs_fp && bus.id_rs == 5'd0)
                          && (w_rs_pend != 3'd0);
    assign w_rt_haz     = bus.id_rt_used && !(!bus.id_rt_fp && bus.id_rt == 5'd0)
                          && (w_rt_pend != 3'd0);
    assign w_waw_haz    = bus.id_dst_we && !w_dst_is_r0 && (w_dst_pend != 3'd0);
    assign w_struct_haz = bus.id_is_fpop && (r_fpu_cnt != 3'd0);

    assign w_stall = bus.id_valid && (w_rs_haz || w_rt_haz || w_waw_haz || w_struct_haz);
    assign w_issue = bus.id_valid && !w_stall;
    assign w_wr_en = w_issue && bus.id_dst_we && !w_dst_is_r0;

    // FP-unit ops take precedence when both op flags are set; plain ALU
    // results are covered by forwarding, so they leave the counter at 0.
    assign w_load_val = bus.id_is_fpop ? c_fp_lat :
                        bus.id_is_load ? 3'd1     : 3'd0;

    // Reset forces the pipeline front end to hold and inject NOPs.
    assign bus.pc_write     = !reset && !w_stall;
    assign bus.ifid_write   = !reset && !w_stall;
    assign bus.idex_bubble  = reset || w_stall;
    assign bus.ifid_flush   = reset || (bus.id_branch_taken && w_issue);
    assign bus.fp_busy      = !reset && (r_fpu_cnt != 3'd0);
    assign bus.stall_cycles = r_stall_cycles;

    // Register countdowns: a reload on issue wins over the decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_gpr_cnt[i] <= 3'd0;
                r_fpr_cnt[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (w_wr_en && !bus.id_dst_fp && bus.id_dst == 5'(i)) begin
                    r_gpr_cnt[i] <= w_load_val;
                end else if (r_gpr_cnt[i] != 3'd0) begin
                    r_gpr_cnt[i] <= r_gpr_cnt[i] - 3'd1;
                end
                if (w_wr_en && bus.id_dst_fp && bus.id_dst == 5'(i)) begin
                    r_fpr_cnt[i] <= w_load_val;
                end else if (r_fpr_cnt[i] != 3'd0) begin
                    r_fpr_cnt[i] <= r_fpr_cnt[i] - 3'd1;
                end
            end
        end
    end

    // FP-unit occupancy and saturating stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fpu_cnt      <= 3'd0;
            r_stall_cycles <= '0;
        end else begin
            if (w_issue && bus.id_is_fpop) begin
                r_fpu_cnt <= c_fp_lat;
            end else if (r_fpu_cnt != 3'd0) begin
                r_fpu_cnt <= r_fpu_cnt - 3'd1;
            end
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard. A directed table
//                of instruction/expected-output rows, a hand sequence for
//                asynchronous reset mid-stall, then randomized instructions
//                checked against a behavioural scoreboard model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
    localparam int FP_LAT = 4;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic reset;

    hazard_scoreboard_if #(.CNT_W(CNT_W)) bus ();

    hazard_scoreboard #(.FP_LAT(FP_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic       rs_used;
        logic       rs_fp;
        logic [4:0] rt;
        logic       rt_used;
        logic       rt_fp;
        logic [4:0] dst;
        logic       dst_we;
        logic       dst_fp;
        logic       is_load;
        logic       is_fpop;
        logic       br;
    } ins_t;

    typedef struct {
        ins_t ins;
        logic pc;
        logic flush;
        logic bubble;
        logic busy;
        int   sc;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[$];

    // Behavioural model: cycles remaining per register (index {fp, reg}).
    int m_pend[64];
    int m_fpu;
    int m_sc;

    function automatic ins_t mk(logic v, logic [4:0] rs, logic rsu, logic rsfp,
                                logic [4:0] rt, logic rtu, logic rtfp,
                                logic [4:0] dst, logic we, logic dfp,
                                logic ld, logic fp, logic br);
        ins_t t;
        t.valid = v;   t.rs = rs;   t.rs_used = rsu; t.rs_fp = rsfp;
        t.rt = rt;     t.rt_used = rtu; t.rt_fp = rtfp;
        t.dst = dst;   t.dst_we = we;   t.dst_fp = dfp;
        t.is_load = ld; t.is_fpop = fp; t.br = br;
        return t;
    endfunction

    function automatic ins_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic ins_t lw(logic [4:0] d, logic dfp);
        return mk(1, 29, 1, 0, 0, 0, 0, d, 1, dfp, 1, 0, 0);
    endfunction
    function automatic ins_t fpop(logic [4:0] d, logic [4:0] a, logic [4:0] b);
        return mk(1, a, 1, 1, b, 1, 1, d, 1, 1, 0, 1, 0);
    endfunction
    function automatic ins_t alu(logic [4:0] d, logic [4:0] a, logic [4:0] b);
        return mk(1, a, 1, 0, b, 1, 0, d, 1, 0, 0, 0, 0);
    endfunction
    function automatic ins_t swc1(logic [4:0] ft);
        return mk(1, 29, 1, 0, ft, 1, 1, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic ins_t beq(logic [4:0] a, logic [4:0] b);
        return mk(1, a, 1, 0, b, 1, 0, 0, 0, 0, 0, 0, 1);
    endfunction

    function automatic ins_t rand_ins();
        ins_t t;
        t.valid   = ($urandom_range(0, 9) != 0);
        t.rs      = 5'($urandom_range(0, 5));
        t.rt      = 5'($urandom_range(0, 5));
        t.dst     = 5'($urandom_range(0, 5));
        t.rs_used = 1'($urandom);
        t.rt_used = 1'($urandom);
        t.rs_fp   = 1'($urandom);
        t.rt_fp   = 1'($urandom);
        t.dst_we  = ($urandom_range(0, 3) != 0);
        t.dst_fp  = 1'($urandom);
        t.is_load = ($urandom_range(0, 3) == 0);
        t.is_fpop = ($urandom_range(0, 3) == 0);
        t.br      = ($urandom_range(0, 6) == 0);
        return t;
    endfunction

    function automatic vec_t row(ins_t i, logic pc, logic fl, logic bub,
                                 logic busy, int sc);
        vec_t v;
        v.ins = i; v.pc = pc; v.flush = fl; v.bubble = bub; v.busy = busy; v.sc = sc;
        return v;
    endfunction

    task automatic apply(input ins_t t);
        bus.id_valid        = t.valid;
        bus.id_rs           = t.rs;
        bus.id_rs_used      = t.rs_used;
        bus.id_rs_fp        = t.rs_fp;
        bus.id_rt           = t.rt;
        bus.id_rt_used      = t.rt_used;
        bus.id_rt_fp        = t.rt_fp;
        bus.id_dst          = t.dst;
        bus.id_dst_we       = t.dst_we;
        bus.id_dst_fp       = t.dst_fp;
        bus.id_is_load      = t.is_load;
        bus.id_is_fpop      = t.is_fpop;
        bus.id_branch_taken = t.br;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_pend[i] = 0;
        m_fpu = 0;
        m_sc  = 0;
    endtask

    function automatic bit is_r0(logic fp, logic [4:0] r);
        return !fp && (r == 5'd0);
    endfunction

    function automatic bit m_stall();
        bit h = 0;
        if (!bus.id_valid) return 0;
        if (bus.id_rs_used && !is_r0(bus.id_rs_fp, bus.id_rs)
            && m_pend[{bus.id_rs_fp, bus.id_rs}] > 0) h = 1;
        if (bus.id_rt_used && !is_r0(bus.id_rt_fp, bus.id_rt)
            && m_pend[{bus.id_rt_fp, bus.id_rt}] > 0) h = 1;
        if (bus.id_dst_we && !is_r0(bus.id_dst_fp, bus.id_dst)
            && m_pend[{bus.id_dst_fp, bus.id_dst}] > 0) h = 1;
        if (bus.id_is_fpop && m_fpu > 0) h = 1;
        return h;
    endfunction

    // One clock edge of the model: everything counts down, then an issuing
    // instruction posts its destination latency and claims the FP unit.
    task automatic model_edge();
        bit st = m_stall();
        for (int i = 0; i < 64; i++) if (m_pend[i] > 0) m_pend[i]--;
        if (m_fpu > 0) m_fpu--;
        if (bus.id_valid && !st) begin
            if (bus.id_dst_we && !is_r0(bus.id_dst_fp, bus.id_dst))
                m_pend[{bus.id_dst_fp, bus.id_dst}] =
                    bus.id_is_fpop ? FP_LAT : (bus.id_is_load ? 1 : 0);
            if (bus.id_is_fpop) m_fpu = FP_LAT;
        end
        if (st && m_sc < (1 << CNT_W) - 1) m_sc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vs(input string tag, input logic pc, input logic fl,
                            input logic bub, input logic busy, input int sc);
        chk({tag, " pc_write"},     32'(bus.pc_write),     32'(pc));
        chk({tag, " ifid_write"},   32'(bus.ifid_write),   32'(pc));
        chk({tag, " ifid_flush"},   32'(bus.ifid_flush),   32'(fl));
        chk({tag, " idex_bubble"},  32'(bus.idex_bubble),  32'(bub));
        chk({tag, " fp_busy"},      32'(bus.fp_busy),      32'(busy));
        chk({tag, " stall_cycles"}, 32'(bus.stall_cycles), 32'(sc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hold;
        bit st;

        // rows: instruction, pc_write, ifid_flush, idex_bubble, fp_busy, stall_cycles
        tbl.push_back(row(lw(8, 0),        1, 0, 0, 0, 0));   // load-use
        tbl.push_back(row(alu(9, 8, 8),    0, 0, 1, 0, 0));
        tbl.push_back(row(alu(9, 8, 8),    1, 0, 0, 0, 1));
        tbl.push_back(row(fpop(2, 0, 1),   1, 0, 0, 0, 1));   // FP RAW
        tbl.push_back(row(swc1(2),         0, 0, 1, 1, 1));
        tbl.push_back(row(swc1(2),         0, 0, 1, 1, 2));
        tbl.push_back(row(swc1(2),         0, 0, 1, 1, 3));
        tbl.push_back(row(swc1(2),         0, 0, 1, 1, 4));
        tbl.push_back(row(swc1(2),         1, 0, 0, 0, 5));
        tbl.push_back(row(fpop(2, 0, 1),   1, 0, 0, 0, 5));   // integer $2 unaffected
        tbl.push_back(row(alu(3, 2, 0),    1, 0, 0, 1, 5));
        tbl.push_back(row(nop(),           1, 0, 0, 1, 5));
        tbl.push_back(row(nop(),           1, 0, 0, 1, 5));
        tbl.push_back(row(nop(),           1, 0, 0, 1, 5));
        tbl.push_back(row(nop(),           1, 0, 0, 0, 5));
        tbl.push_back(row(fpop(6, 0, 1),   1, 0, 0, 0, 5));   // structural
        tbl.push_back(row(fpop(8, 10, 11), 0, 0, 1, 1, 5));
        tbl.push_back(row(fpop(8, 10, 11), 0, 0, 1, 1, 6));
        tbl.push_back(row(fpop(8, 10, 11), 0, 0, 1, 1, 7));
        tbl.push_back(row(fpop(8, 10, 11), 0, 0, 1, 1, 8));
        tbl.push_back(row(fpop(8, 10, 11), 1, 0, 0, 0, 9));
        tbl.push_back(row(beq(3, 5),       1, 1, 0, 1, 9));   // branch, ready
        tbl.push_back(row(lw(10, 0),       1, 0, 0, 1, 9));
        tbl.push_back(row(beq(10, 5),      0, 0, 1, 1, 9));   // branch, load pending
        tbl.push_back(row(beq(10, 5),      1, 1, 0, 1, 10));
        tbl.push_back(row(lw(0, 0),        1, 0, 0, 0, 10));  // r0
        tbl.push_back(row(alu(11, 0, 0),   1, 0, 0, 0, 10));
        tbl.push_back(row(fpop(4, 0, 1),   1, 0, 0, 0, 10));  // WAW
        tbl.push_back(row(lw(4, 1),        0, 0, 1, 1, 10));
        tbl.push_back(row(lw(4, 1),        0, 0, 1, 1, 11));
        tbl.push_back(row(lw(4, 1),        0, 0, 1, 1, 12));
        tbl.push_back(row(lw(4, 1),        0, 0, 1, 1, 13));
        tbl.push_back(row(lw(4, 1),        1, 0, 0, 0, 14));
        tbl.push_back(row(swc1(4),         0, 0, 1, 0, 14));
        tbl.push_back(row(swc1(4),         1, 0, 0, 0, 15));
        tbl.push_back(row(nop(),           1, 0, 0, 0, 15));

        reset = 1'b1;
        apply(nop());
        model_reset();
        #1;
        check_vs("in_reset", 0, 1, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].ins);
            #3;
            check_vs($sformatf("row%0d", i), tbl[i].pc, tbl[i].flush,
                     tbl[i].bubble, tbl[i].busy, tbl[i].sc);
            tick();
        end

        // Asynchronous reset in the middle of an FP RAW stall.
        apply(fpop(2, 0, 1));
        tick();
        apply(swc1(2));
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_vs("async_reset", 0, 1, 1, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_vs("post_reset", 1, 0, 0, 0, 0);
        tick();
        #3;
        check_vs("post_reset_edge", 1, 0, 0, 0, 0);
        tick();

        // Randomized traffic; a stalled instruction stays in ID.
        hold = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!hold) apply(rand_ins());
            #3;
            st = m_stall();
            check_vs($sformatf("rand%0d", n), !st,
                     bus.id_valid && bus.id_branch_taken && !st,
                     st, m_fpu > 0, m_sc);
            hold = st;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
